pipe_latch_nw: RTL

Parametrised N-lane pipeline register with a valid/ready handshake, a one-bundle skid buffer, per-lane valid masks, lane kill and synchronous flush. It is the general replacement for fixed-width inter-stage latches (fetch/decode, decode/execute) in the multi-wide processor: a stage stalls without combinational ready paths, and branch squashes clear individual lanes or the whole stage.

---
 rtl/pipe_latch_nw.sv | 104 ++++++++++
 1 files changed

// File: rtl/pipe_latch_nw.sv
// pipe_latch_nw: N-lane pipeline latch with valid/ready, one-bundle skid, lane kill and flush.
module pipe_latch_nw #(
  parameter int LANES        = 2,
  parameter int LANE_W       = 48,
  parameter int ZERO_INVALID = 1,
  parameter int DROP_EMPTY   = 1,
  parameter int CNT_W        = 16
) (
  input  logic                    clock,
  input  logic                    ctrl_reset_n,
  input  logic                    in_valid,
  input  logic [LANES-1:0]        in_mask,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    in_ready,
  input  logic [LANES-1:0]        lane_kill,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [LANES-1:0]        out_mask,
  output logic [LANES*LANE_W-1:0] out_data,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        stall_cnt
);
  logic                    main_full_q, main_full_d;
  logic [LANES-1:0]        main_mask_q, main_mask_d;
  logic [LANES*LANE_W-1:0] main_data_q, main_data_d;
  logic                    skid_full_q, skid_full_d;
  logic [LANES-1:0]        skid_mask_q, skid_mask_d;
  logic [LANES*LANE_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic [LANES-1:0]        cap_mask;
  logic [LANES*LANE_W-1:0] cap_data;
  logic                    in_fire, cap_ok;

  assign in_ready  = ~skid_full_q;
  assign out_valid = main_full_q;
  assign out_mask  = main_mask_q;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    cap_mask = in_mask & ~lane_kill;
    cap_data = in_data;
    for (int i = 0; i < LANES; i++)
      if (ZERO_INVALID != 0 && !cap_mask[i]) cap_data[i*LANE_W +: LANE_W] = '0;
    in_fire = in_valid & ~skid_full_q & ~flush;
    cap_ok  = in_fire & ((DROP_EMPTY == 0) | (|cap_mask));
  end

  // Empty registers always hold zero mask/data so outputs read as NOP when idle.
  always_comb begin
    main_full_d = main_full_q;
    main_mask_d = main_mask_q;
    main_data_d = main_data_q;
    skid_full_d = skid_full_q;
    skid_mask_d = skid_mask_q;
    skid_data_d = skid_data_q;
    stall_cnt_d = (main_full_q & ~out_ready & ~flush & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    if (flush) begin
      main_full_d = 1'b0;
      main_mask_d = '0;
      main_data_d = '0;
      skid_full_d = 1'b0;
      skid_mask_d = '0;
      skid_data_d = '0;
    end else if (!main_full_q || out_ready) begin
      if (skid_full_q) begin
        main_full_d = 1'b1;
        main_mask_d = skid_mask_q;
        main_data_d = skid_data_q;
        skid_full_d = 1'b0;
        skid_mask_d = '0;
        skid_data_d = '0;
      end else begin
        main_full_d = cap_ok;
        main_mask_d = cap_ok ? cap_mask : '0;
        main_data_d = cap_ok ? cap_data : '0;
      end
    end else if (cap_ok) begin
      skid_full_d = 1'b1;
      skid_mask_d = cap_mask;
      skid_data_d = cap_data;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      main_full_q <= 1'b0;
      main_mask_q <= '0;
      main_data_q <= '0;
      skid_full_q <= 1'b0;
      skid_mask_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      main_full_q <= main_full_d;
      main_mask_q <= main_mask_d;
      main_data_q <= main_data_d;
      skid_full_q <= skid_full_d;
      skid_mask_q <= skid_mask_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule
